// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // LSB position of slice k in a flat bus of w-bit fields
    function automatic int unsigned rd_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or a clear request, then enters RUN.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_n;
            clr_ptr <= clr_ptr_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_ptr_n = clr_ptr;
        clr_we    = 1'b0;
        ready     = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_ptr_n = clr_ptr + 1'b1;
                if (clr_ptr == LAST) begin
                    state_n   = ST_RUN;
                    clr_ptr_n = '0;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
                if (clr_req) begin
                    state_n   = ST_CLEAR;
                    clr_ptr_n = '0;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional zero register, write bypass and sequenced clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int NREAD   = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic                    ready
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              wr_ok;
    logic              user_we;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (run)
    );

    assign ready = run;

    // A write is honoured only in RUN, to an in-range non-zero-register entry, and not alongside a clear request
    assign wr_ok   = ({1'b0, wr_addr} < DEPTH_L) && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign user_we = run && !rst && !clr_req && wr_en && wr_ok;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr[IDX_W-1:0]] <= '0;
        end else if (user_we) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] q;

        assign addr = rd_addr[rd_lsb(k, ADDR_W) +: ADDR_W];

        // Zero register and out-of-range checks take priority over forwarding
        always_comb begin
            val = '0;
            if ({1'b0, addr} >= DEPTH_L) begin
                val = '0;
            end else if ((ZERO_R0 != 0) && (addr == '0)) begin
                val = '0;
            end else if ((BYPASS != 0) && user_we && (wr_addr == addr)) begin
                val = wr_data;
            end else begin
                val = mem[addr[IDX_W-1:0]];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || !run) begin
                q <= '0;
            end else begin
                q <= val;
            end
        end

        assign rd_data[rd_lsb(k, DATA_W) +: DATA_W] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register-file configurations driven in lockstep against a behavioural model.
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int ND = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_req;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data0, rd_data1;
    logic             ready0, ready1;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DW), .ADDR_W (AW), .DEPTH (32), .NREAD (NR), .ZERO_R0 (1), .BYPASS (1)
    ) dut (
        .clk (clk), .rst (rst), .clr_req (clr_req), .wr_en (wr_en), .wr_addr (wr_addr),
        .wr_data (wr_data), .rd_addr (rd_addr), .rd_data (rd_data0), .ready (ready0)
    );

    regfile_mp #(
        .DATA_W (DW), .ADDR_W (AW), .DEPTH (24), .NREAD (NR), .ZERO_R0 (0), .BYPASS (0)
    ) dut_alt (
        .clk (clk), .rst (rst), .clr_req (clr_req), .wr_en (wr_en), .wr_addr (wr_addr),
        .wr_data (wr_data), .rd_addr (rd_addr), .rd_data (rd_data1), .ready (ready1)
    );

    int depth_c [ND] = '{32, 24};
    bit zero_c  [ND] = '{1'b1, 1'b0};
    bit byp_c   [ND] = '{1'b1, 1'b0};

    logic [DW-1:0] mdl [ND][32];
    bit            run [ND];
    int            cnt [ND];
    logic [DW-1:0] sb [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int d, input int a);
        if (!run[d] || rst) return '0;
        if (a >= depth_c[d]) return '0;
        if (zero_c[d] && a == 0) return '0;
        if (byp_c[d] && wr_en && !clr_req && int'(wr_addr) == a) return wr_data;
        return mdl[d][a];
    endfunction

    task automatic zero_model(input int d);
        for (int i = 0; i < 32; i++) mdl[d][i] = '0;
    endtask

    // One clock: push expectations from current inputs, advance the model, then compare
    task automatic step();
        logic [DW-1:0] e;
        logic [DW-1:0] act;
        logic          rdy;
        for (int d = 0; d < ND; d++)
            for (int k = 0; k < NR; k++)
                sb.push_back(exp_rd(d, int'(rd_addr[k*AW +: AW])));
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                run[d] = 1'b0; cnt[d] = 0; zero_model(d);
            end else if (!run[d]) begin
                cnt[d]++;
                if (cnt[d] == depth_c[d]) run[d] = 1'b1;
            end else if (clr_req) begin
                run[d] = 1'b0; cnt[d] = 0; zero_model(d);
            end else if (wr_en && int'(wr_addr) < depth_c[d] && !(zero_c[d] && wr_addr == '0)) begin
                mdl[d][wr_addr] = wr_data;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < NR; k++) begin
                e   = sb.pop_front();
                act = (d == 0) ? rd_data0[k*DW +: DW] : rd_data1[k*DW +: DW];
                check($sformatf("rd_d%0d_p%0d", d, k), 32'(act), 32'(e));
            end
            rdy = (d == 0) ? ready0 : ready1;
            check($sformatf("ready_d%0d", d), 32'(rdy), 32'(run[d]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a += 2) begin
            set_rd(a, a + 1);
            step();
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(33);
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int d = 0; d < ND; d++) begin
            run[d] = 1'b0; cnt[d] = 0; zero_model(d);
        end
        step();
        step();
        rst = 1'b0;
        idle(33);

        // Preload, then reset: clear sequence must wipe everything
        for (int a = 1; a < 32; a++) wr(a, DW'(16'h1000 + a * 3));
        read_all();
        do_reset();
        read_all();

        // Basic write/read including an address beyond the shallower configuration
        wr(5, 16'hBEEF);
        wr(31, 16'h1234);
        set_rd(5, 31);
        step();
        step();
        set_rd(23, 24);
        wr(23, 16'h5A5A);
        step();

        // Bypass versus pre-write value
        wr(7, 16'h1111);
        set_rd(7, 7);
        wr(7, 16'hA5A5);
        step();

        // Zero register
        wr(0, 16'hFFFF);
        set_rd(0, 0);
        step();
        step();

        // Clear request with a simultaneous write
        wr(9, 16'h0F0F);
        set_rd(9, 5);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'hDEAD;
        step();
        clr_req = 1'b0; wr_en = 1'b0;
        idle(33);
        read_all();

        // Reset ten cycles into a clear restarts the full sequence
        for (int a = 1; a < 24; a++) wr(a, DW'($urandom_range(1, 16'hFFFF)));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        idle(10);
        do_reset();
        read_all();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 31));
            wr_data = DW'($urandom);
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            clr_req = ($urandom_range(0, 99) == 0);
            step();
        end
        clr_req = 1'b0; wr_en = 1'b0;
        idle(33);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
